// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and helpers for the round-robin shared-register arbiter.
// The half-swap helper works on any even width up to MAX_WIDTH.
package shared_reg_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int MAX_WIDTH = 64;

  // Exchanges the upper and lower halves of the low `width` bits of x.
  function automatic logic [MAX_WIDTH-1:0] swap_halves(input logic [MAX_WIDTH-1:0] x,
                                                       input int width);
    logic [MAX_WIDTH-1:0] r;
    logic [5:0]           src;
    r = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      src = 6'((i + width / 2) % width);
      if (i < width) r[i] = x[src];
    end
    return r;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: grants the first requester at or after
// (last + 1) mod NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   grant,
  output logic            any
);

  logic [IW-1:0] cand;

  // Scan from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    grant = '0;
    cand  = '0;
    any   = |req;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (req[cand]) grant = cand;
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Shares one WIDTH-bit register between NREQ requesters, each of which sees it
// through a straight or half-swapped view. One transaction in flight at a time.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  ASYNCRESET,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_write,
  input  logic [NREQ-1:0]       req_swap,
  input  logic [NREQ*WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [WIDTH-1:0]      reg_value,
  output logic                  busy
);

  localparam int IW = $clog2(NREQ);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  reg_q, reg_d;
  logic [IW-1:0]     last_q, last_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic              swap_q, swap_d;
  logic [NREQ-1:0]   req_ready_q, req_ready_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;

  logic [IW-1:0]     pick_grant;
  logic              pick_any;
  logic [WIDTH-1:0]  wdata_g;

  function automatic logic [WIDTH-1:0] swapw(input logic [WIDTH-1:0] x);
    return WIDTH'(swap_halves(MAX_WIDTH'(x), WIDTH));
  endfunction

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (req_valid),
    .last  (last_q),
    .grant (pick_grant),
    .any   (pick_any)
  );

  assign wdata_g = req_wdata[grant_q*WIDTH +: WIDTH];

  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a value unassigned and no latch is inferred.
    state_d     = state_q;
    reg_d       = reg_q;
    last_d      = last_q;
    grant_d     = grant_q;
    swap_d      = swap_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_data_d  = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_grant;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!req_valid[grant_q]) begin
          state_d = IDLE;
        end else begin
          req_ready_d = NREQ'(1) << grant_q;
          if (req_write[grant_q]) reg_d = req_swap[grant_q] ? swapw(wdata_g) : wdata_g;
          swap_d  = req_swap[grant_q];
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid_d = NREQ'(1) << grant_q;
        rsp_data_d  = swap_q ? swapw(reg_q) : reg_q;
        last_d      = grant_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q     <= IDLE;
      // NOTE: the storage register is a single word, so resetting it is cheap
      // and gives requesters a defined value after an aborted write.
      reg_q       <= '0;
      last_q      <= IW'(NREQ - 1);
      grant_q     <= '0;
      swap_q      <= 1'b0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      reg_q       <= reg_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      swap_q      <= swap_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign reg_value = reg_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter: a high-level model predicts grant
// order and response data; monitors compare whenever the DUT pulses outputs.
module tb_shared_reg_arbiter;

  localparam int N = 4;
  localparam int W = 16;
  localparam int H = W / 2;

  logic           CLK = 1'b0;
  logic           ASYNCRESET;
  logic [N-1:0]   req_valid, req_write, req_swap;
  logic [N*W-1:0] req_wdata;
  logic [N-1:0]   req_ready, rsp_valid;
  logic [W-1:0]   rsp_data, reg_value;
  logic           busy;

  always #5 CLK = ~CLK;

  shared_reg_arbiter #(
    .NREQ  (N),
    .WIDTH (W)
  ) dut (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_swap   (req_swap),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .reg_value  (reg_value),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int           exp_rdy_q[$];
  int           exp_rsp_idx_q[$];
  logic [W-1:0] exp_rsp_data_q[$];

  logic [W-1:0] m_reg;
  int           m_last;
  int           mon_e;
  logic [W-1:0] got;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic [W-1:0] sw(input logic [W-1:0] x);
    return {x[H-1:0], x[W-1:H]};
  endfunction

  // One completed transaction in the reference model.
  function automatic void model_txn(input int idx, input bit wr, input bit s, input logic [W-1:0] d);
    if (wr) m_reg = s ? sw(d) : d;
    m_last = idx;
    exp_rdy_q.push_back(idx);
    exp_rsp_idx_q.push_back(idx);
    exp_rsp_data_q.push_back(s ? sw(m_reg) : m_reg);
  endfunction

  always @(negedge CLK) begin
    if (!ASYNCRESET) begin
      if (req_ready != '0) begin
        if (exp_rdy_q.size() == 0) check("unexpected_ready", req_ready, 0);
        else begin
          mon_e = exp_rdy_q.pop_front();
          check("ready_grant", req_ready, 1 << mon_e);
        end
      end
      if (rsp_valid != '0) begin
        if (exp_rsp_idx_q.size() == 0) check("unexpected_rsp", rsp_valid, 0);
        else begin
          mon_e = exp_rsp_idx_q.pop_front();
          check("rsp_valid", rsp_valid, 1 << mon_e);
          check("rsp_data", rsp_data, exp_rsp_data_q.pop_front());
        end
      end else begin
        check("rsp_data_zero_idle", rsp_data, 0);
      end
    end
  end

  task automatic set_req(input int i, input bit v, input bit wr, input bit s, input logic [W-1:0] d);
    req_valid[i]         = v;
    req_write[i]         = wr;
    req_swap[i]          = s;
    req_wdata[i*W +: W]  = d;
  endtask

  task automatic do_reset();
    ASYNCRESET = 1'b1;
    req_valid  = '0;
    req_write  = '0;
    req_swap   = '0;
    req_wdata  = '0;
    repeat (2) @(negedge CLK);
    exp_rdy_q.delete();
    exp_rsp_idx_q.delete();
    exp_rsp_data_q.delete();
    m_reg      = '0;
    m_last     = N - 1;
    ASYNCRESET = 1'b0;
  endtask

  // Lone request with cycle-exact timing checks; returns the response data.
  task automatic single(input int idx, input bit wr, input bit s, input logic [W-1:0] d,
                        output logic [W-1:0] data);
    @(negedge CLK);
    set_req(idx, 1'b1, wr, s, d);
    model_txn(idx, wr, s, d);
    @(negedge CLK);
    check("single_busy_access", busy, 1);
    check("single_no_early_ready", req_ready, 0);
    @(negedge CLK);
    check("single_ready_t1", req_ready, 1 << idx);
    check("single_reg_value", reg_value, m_reg);
    req_valid[idx] = 1'b0;
    @(negedge CLK);
    check("single_rsp_t2", rsp_valid, 1 << idx);
    data = rsp_data;
    @(negedge CLK);
    check("single_idle", busy, 0);
  endtask

  // All requesters in mask raise valid together; model predicts round-robin order.
  task automatic batch(input logic [N-1:0] mask, input bit force_read);
    logic [N-1:0] pend;
    bit           wr[N];
    bit           s[N];
    logic [W-1:0] d[N];
    int           t_rdy[$];
    int           idle_cnt, budget, j;
    @(negedge CLK);
    for (int i = 0; i < N; i++) begin
      wr[i] = force_read ? 1'b0 : 1'($urandom_range(0, 1));
      s[i]  = 1'($urandom_range(0, 1));
      d[i]  = W'($urandom);
      if (mask[i]) set_req(i, 1'b1, wr[i], s[i], d[i]);
    end
    pend = mask;
    while (pend != '0) begin
      for (int k = 1; k <= N; k++) begin
        j = (m_last + k) % N;
        if (pend[j]) begin
          model_txn(j, wr[j], s[j], d[j]);
          pend[j] = 1'b0;
          break;
        end
      end
    end
    budget   = 0;
    idle_cnt = 0;
    while (req_valid != '0 && budget < 8 * N) begin
      @(negedge CLK);
      budget++;
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          req_valid[i] = 1'b0;
          t_rdy.push_back(cyc);
        end
      end
      if (t_rdy.size() > 0 && req_valid != '0 && !busy) idle_cnt++;
    end
    check("batch_all_served", req_valid, 0);
    for (int i = 1; i < t_rdy.size(); i++) check("grant_spacing", t_rdy[i] - t_rdy[i-1], 3);
    check("busy_idle_gaps", idle_cnt, $countones(mask) - 1);
    req_valid = '0;
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    @(negedge CLK);
    check("reset_ready", req_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_reg", reg_value, 0);
    check("reset_busy", busy, 0);

    // Straight write from requester 0.
    single(0, 1'b1, 1'b0, 16'h1234, got);
    check("r0_write_rsp", got, 16'h1234);
    check("r0_write_reg", reg_value, 16'h1234);

    // Swapped write, straight read, swapped read.
    single(2, 1'b1, 1'b1, 16'h1234, got);
    check("r2_swap_write_reg", reg_value, 16'h3412);
    single(1, 1'b0, 1'b0, 16'h0000, got);
    check("r1_straight_read", got, 16'h3412);
    single(2, 1'b0, 1'b1, 16'h0000, got);
    check("r2_swap_read", got, 16'h1234);

    // All four read together after reset: order 0,1,2,3.
    do_reset();
    batch(4'b1111, 1'b1);

    // last=1 with requesters 0 and 3: 3 before 0.
    do_reset();
    single(1, 1'b1, 1'b0, 16'h00C3, got);
    batch(4'b1001, 1'b0);

    // Abort: requester 1 drops valid in ACCESS.
    do_reset();
    single(0, 1'b1, 1'b0, 16'hA5C3, got);
    @(negedge CLK);
    set_req(1, 1'b1, 1'b1, 1'b0, 16'hFFFF);
    @(negedge CLK);
    check("abort_busy_access", busy, 1);
    req_valid[1] = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check("abort_no_ready", req_ready, 0);
      check("abort_no_rsp", rsp_valid, 0);
    end
    check("abort_reg_unchanged", reg_value, 16'hA5C3);
    batch(4'b0011, 1'b0);

    // Reset pulsed in the ACCESS cycle of a write.
    single(3, 1'b1, 1'b0, 16'h5A5A, got);
    @(negedge CLK);
    set_req(0, 1'b1, 1'b1, 1'b0, 16'hBEEF);
    @(negedge CLK);
    check("rst_mid_busy_access", busy, 1);
    #2 ASYNCRESET = 1'b1;
    #1;
    check("rst_mid_reg", reg_value, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ready", req_ready, 0);
    check("rst_mid_rsp_valid", rsp_valid, 0);
    check("rst_mid_rsp_data", rsp_data, 0);
    do_reset();
    repeat (3) begin
      @(negedge CLK);
      check("post_rst_reg", reg_value, 0);
      check("post_rst_no_rsp", rsp_valid, 0);
    end

    // Randomized traffic.
    for (int b = 0; b < 40; b++) begin
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      batch(N'($urandom_range(1, (1 << N) - 1)), 1'b0);
    end

    repeat (3) @(negedge CLK);
    check("ready_queue_drained", exp_rdy_q.size(), 0);
    check("rsp_queue_drained", exp_rsp_idx_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
